// File: rtl/noc_ni_pkg.sv
// noc_ni_pkg -- shared definitions for the processor-side network interface.
//   Flit geometry, flit type codes, HEAD field offsets, the TX request record
//   and the TX/RX state enums, plus helpers that build HEAD and TAIL flits.
package noc_ni_pkg;

   localparam int FLIT_W        = 34;
   localparam int DATA_W        = 32;
   localparam int NODE_W        = 2;
   localparam int TYPE_LSB      = 32;
   localparam int HEAD_DEST_LSB = 0;
   localparam int HEAD_SRC_LSB  = 2;

   localparam logic [1:0] FLIT_HEAD = 2'b10;
   localparam logic [1:0] FLIT_TAIL = 2'b01;

   typedef enum logic [1:0] {TX_IDLE, TX_HEAD, TX_TAIL}      tx_state_e;
   typedef enum logic [1:0] {RX_IDLE, RX_WAIT_TAIL, RX_HOLD} rx_state_e;

   // One queued send request.
   typedef struct packed {
      logic [NODE_W-1:0] dest;
      logic [DATA_W-1:0] data;
   } tx_req_t;

   function automatic logic [FLIT_W-1:0] make_head(input logic [NODE_W-1:0] dest,
                                                   input logic [NODE_W-1:0] src);
      logic [FLIT_W-1:0] f;
      f = '0;
      f[TYPE_LSB +: 2]           = FLIT_HEAD;
      f[HEAD_DEST_LSB +: NODE_W] = dest;
      f[HEAD_SRC_LSB +: NODE_W]  = src;
      return f;
   endfunction

   function automatic logic [FLIT_W-1:0] make_tail(input logic [DATA_W-1:0] data);
      return {FLIT_TAIL, data};
   endfunction

endpackage

// File: rtl/ni_tx_fifo.sv
// ni_tx_fifo -- small circular FIFO holding processor send requests.
//   clk, rst       : clock, asynchronous active-low reset (empties the FIFO)
//   push, data_in  : write request (ignored while full)
//   pop            : drop the front entry (ignored while empty)
//   data_out       : front entry;  data_peek : entry behind the front
//   full, empty    : occupancy flags derived from the registered count
//   count          : number of stored entries
module ni_tx_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 34
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         data_in,
   output logic [WIDTH-1:0]         data_out,
   output logic [WIDTH-1:0]         data_peek,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // NOTE: storage is not reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data_in;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign data_out  = mem[rd_ptr];
   // Power-of-two depth lets the pointer wrap naturally.
   assign data_peek = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/ni_proc_adapter.sv
// ni_proc_adapter -- processor-side network interface.
//   TX: proc_valid/proc_dest/proc_data are queued and sent to the router as a
//       HEAD+TAIL packet on flit_out/flit_out_valid/flit_out_ready.
//       tx_full flags a full queue; ovf_err is sticky after a dropped request.
//   RX: HEAD+TAIL packets on flit_in/flit_in_valid/flit_in_ready are
//       reassembled; the payload is offered on wd_NI with mips_ni pending and
//       data_valid strobing when proc_ready_in accepts it. rx_err is sticky.
//   clk, rst: clock and asynchronous active-low reset.
//   Optional: define NI_STATS_EN to add tx_pkt_cnt / rx_pkt_cnt counters.
module ni_proc_adapter
   import noc_ni_pkg::*;
#(
   parameter logic [1:0] NODE_ID  = 2'd0,
   parameter int         TX_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              proc_valid,
   input  logic [1:0]        proc_dest,
   input  logic [31:0]       proc_data,
   input  logic              proc_ready_in,
   output logic              tx_full,
   output logic              ovf_err,
   output logic              rx_err,
   output logic              mips_ni,
   output logic              data_valid,
   output logic [31:0]       wd_NI,
`ifdef NI_STATS_EN
   output logic [15:0]       tx_pkt_cnt,
   output logic [15:0]       rx_pkt_cnt,
`endif
   output logic [FLIT_W-1:0] flit_out,
   output logic              flit_out_valid,
   input  logic              flit_out_ready,
   input  logic [FLIT_W-1:0] flit_in,
   input  logic              flit_in_valid,
   output logic              flit_in_ready
);

   localparam int CNT_W = $clog2(TX_DEPTH) + 1;

   // ---------------------------------------------------------------- TX ---
   tx_req_t            req_in, front, peek;
   logic               fifo_empty, fifo_pop;
   logic [CNT_W-1:0]   fifo_count;
   tx_state_e          tx_state, tx_state_next;
   logic [FLIT_W-1:0]  flit_next;
   logic               valid_next;

   assign req_in = '{dest: proc_dest, data: proc_data};

   ni_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH($bits(tx_req_t))) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (proc_valid),
      .pop       (fifo_pop),
      .data_in   (req_in),
      .data_out  (front),
      .data_peek (peek),
      .full      (tx_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // The flit register is loaded with the flit of the state being entered,
   // so the output stays stable while the router stalls.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no latches.
      tx_state_next = tx_state;
      flit_next     = flit_out;
      valid_next    = flit_out_valid;
      fifo_pop      = 1'b0;
      unique case (tx_state)
         TX_IDLE: if (!fifo_empty) begin
            tx_state_next = TX_HEAD;
            flit_next     = make_head(front.dest, NODE_ID);
            valid_next    = 1'b1;
         end
         TX_HEAD: if (flit_out_ready) begin
            tx_state_next = TX_TAIL;
            flit_next     = make_tail(front.data);
         end
         TX_TAIL: if (flit_out_ready) begin
            fifo_pop = 1'b1;
            // Another entry behind the front: go straight to its head.
            if (fifo_count > CNT_W'(1)) begin
               tx_state_next = TX_HEAD;
               flit_next     = make_head(peek.dest, NODE_ID);
            end else begin
               tx_state_next = TX_IDLE;
               valid_next    = 1'b0;
            end
         end
         default: tx_state_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state       <= TX_IDLE;
         flit_out       <= '0;
         flit_out_valid <= 1'b0;
         ovf_err        <= 1'b0;
      end else begin
         tx_state       <= tx_state_next;
         flit_out       <= flit_next;
         flit_out_valid <= valid_next;
         // A pop in the same cycle does not rescue a request seen while full.
         if (proc_valid && tx_full) ovf_err <= 1'b1;
      end
   end

   // ---------------------------------------------------------------- RX ---
   rx_state_e   rx_state, rx_state_next;
   logic [1:0]  in_type;
   logic        rx_err_set, wd_load;

   assign in_type       = flit_in[TYPE_LSB +: 2];
   assign flit_in_ready = (rx_state != RX_HOLD);
   assign mips_ni       = (rx_state == RX_HOLD);
   assign data_valid    = mips_ni && proc_ready_in;

   always_comb begin
      rx_state_next = rx_state;
      rx_err_set    = 1'b0;
      wd_load       = 1'b0;
      unique case (rx_state)
         RX_IDLE: if (flit_in_valid) begin
            if (in_type == FLIT_HEAD) rx_state_next = RX_WAIT_TAIL;
            else                      rx_err_set    = 1'b1;
         end
         RX_WAIT_TAIL: if (flit_in_valid) begin
            if (in_type == FLIT_TAIL) begin
               wd_load       = 1'b1;
               rx_state_next = RX_HOLD;
            end else if (in_type == FLIT_HEAD) begin
               rx_err_set = 1'b1;          // restart: keep waiting for a tail
            end else begin
               rx_err_set    = 1'b1;
               rx_state_next = RX_IDLE;
            end
         end
         RX_HOLD: if (proc_ready_in) rx_state_next = RX_IDLE;
         default: rx_state_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state <= RX_IDLE;
         rx_err   <= 1'b0;
         wd_NI    <= '0;
      end else begin
         rx_state <= rx_state_next;
         if (rx_err_set) rx_err <= 1'b1;
         if (wd_load)    wd_NI  <= flit_in[DATA_W-1:0];
      end
   end

`ifdef NI_STATS_EN
   // -------------------------------------------------------------- stats ---
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_pkt_cnt <= '0;
         rx_pkt_cnt <= '0;
      end else begin
         if (tx_state == TX_TAIL && flit_out_ready) tx_pkt_cnt <= tx_pkt_cnt + 16'd1;
         if (data_valid)                            rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ni_proc_adapter.sv
// tb_ni_proc_adapter -- self-checking bench for ni_proc_adapter
// (NODE_ID=1, TX_DEPTH=2). Define NI_STATS_EN to also cover the counters.
`timescale 1ns/1ps
module tb_ni_proc_adapter;

   localparam logic [1:0] NODE  = 2'd1;
   localparam int         DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        proc_valid, proc_ready_in;
   logic [1:0]  proc_dest;
   logic [31:0] proc_data;
   logic        tx_full, ovf_err, rx_err, mips_ni, data_valid;
   logic [31:0] wd_NI;
   logic [33:0] flit_out, flit_in;
   logic        flit_out_valid, flit_out_ready, flit_in_valid, flit_in_ready;
`ifdef NI_STATS_EN
   logic [15:0] tx_pkt_cnt, rx_pkt_cnt;
`endif

   ni_proc_adapter #(.NODE_ID(NODE), .TX_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .proc_valid     (proc_valid),
      .proc_dest      (proc_dest),
      .proc_data      (proc_data),
      .proc_ready_in  (proc_ready_in),
      .tx_full        (tx_full),
      .ovf_err        (ovf_err),
      .rx_err         (rx_err),
      .mips_ni        (mips_ni),
      .data_valid     (data_valid),
      .wd_NI          (wd_NI),
`ifdef NI_STATS_EN
      .tx_pkt_cnt     (tx_pkt_cnt),
      .rx_pkt_cnt     (rx_pkt_cnt),
`endif
      .flit_out       (flit_out),
      .flit_out_valid (flit_out_valid),
      .flit_out_ready (flit_out_ready),
      .flit_in        (flit_in),
      .flit_in_valid  (flit_in_valid),
      .flit_in_ready  (flit_in_ready)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int exp_tx_pkts = 0;
   int exp_rx_pkts = 0;
   logic exp_rx_err = 1'b0;

   logic [33:0] exp_q[$];
   logic [33:0] got[$];

   task automatic check(input string tag, input logic [33:0] observed, input logic [33:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Flits as the router sees them, built directly from the flit format.
   function automatic logic [33:0] exp_head(input logic [1:0] dest, input logic [1:0] src);
      return {2'b10, 28'h0, src, dest};
   endfunction

   function automatic logic [33:0] exp_tail(input logic [31:0] data);
      return {2'b01, data};
   endfunction

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_flit(input logic [33:0] f);
      flit_in       = f;
      flit_in_valid = 1'b1;
      check("rx_in_ready", flit_in_ready, 1'b1);
      step();
      flit_in_valid = 1'b0;
   endtask

   // One request with an always-ready router: head two edges after the
   // request is sampled, tail one edge later, then idle.
   task automatic send_one(input logic [1:0] d, input logic [31:0] x);
      proc_valid = 1'b1;
      proc_dest  = d;
      proc_data  = x;
      step();
      proc_valid = 1'b0;
      check("lat_not_yet", flit_out_valid, 1'b0);
      step();
      check("head_valid", flit_out_valid, 1'b1);
      check("head_flit", flit_out, exp_head(d, NODE));
      step();
      check("tail_valid", flit_out_valid, 1'b1);
      check("tail_flit", flit_out, exp_tail(x));
      step();
      check("after_valid", flit_out_valid, 1'b0);
      check("after_full", tx_full, 1'b0);
      exp_tx_pkts++;
   endtask

   initial begin : stim
      logic [33:0] hold, f;
      logic        prev_stalled, tail_done;
      logic [7:0]  pat;
      logic [31:0] d;
      int          pend, gaps, kind, dly;
      logic        exp_ovf;

      rst = 1'b0; proc_valid = 1'b0; proc_dest = '0; proc_data = '0;
      proc_ready_in = 1'b0; flit_out_ready = 1'b0; flit_in = '0; flit_in_valid = 1'b0;

      // ---- reset state
      step(); step();
      check("rst_tx_full", tx_full, 1'b0);
      check("rst_ovf", ovf_err, 1'b0);
      check("rst_rx_err", rx_err, 1'b0);
      check("rst_mips_ni", mips_ni, 1'b0);
      check("rst_data_valid", data_valid, 1'b0);
      check("rst_wd", wd_NI, 32'h0);
      check("rst_flit_out", flit_out, 34'h0);
      check("rst_flit_valid", flit_out_valid, 1'b0);
      check("rst_in_ready", flit_in_ready, 1'b1);
      rst = 1'b1;
      step();

      // ---- single send
      flit_out_ready = 1'b1;
      send_one(2'd3, 32'hDEADBEEF);

      // ---- back-pressure and overflow
      flit_out_ready = 1'b0;
      proc_valid = 1'b1; proc_dest = 2'd0; proc_data = 32'hAAAA0001;
      step();
      check("ovf_full_1", tx_full, 1'b0);
      proc_dest = 2'd2; proc_data = 32'hBBBB0002;
      step();
      check("ovf_full_2", tx_full, 1'b1);
      check("ovf_err_0", ovf_err, 1'b0);
      proc_dest = 2'd1; proc_data = 32'hCCCC0003;
      step();
      proc_valid = 1'b0;
      check("ovf_err_1", ovf_err, 1'b1);
      check("ovf_full_3", tx_full, 1'b1);
      check("stall_valid", flit_out_valid, 1'b1);
      check("stall_head", flit_out, exp_head(2'd0, NODE));
      step();
      check("stall_head_2", flit_out, exp_head(2'd0, NODE));

      pat = 8'b1111_1001;   // router ready per cycle, LSB first
      prev_stalled = 1'b0; hold = '0; gaps = 0;
      got.delete();
      for (int i = 0; i < 8; i++) begin
         flit_out_ready = pat[i];
         if (got.size() < 4 && !flit_out_valid) gaps++;
         if (prev_stalled) check("stall_hold", flit_out, hold);
         hold = flit_out;
         prev_stalled = flit_out_valid && !flit_out_ready;
         if (flit_out_valid && flit_out_ready) got.push_back(flit_out);
         step();
      end
      check("flit_count", 34'(got.size()), 34'd4);
      check("flit_gaps", 34'(gaps), 34'd0);
      exp_q = '{exp_head(2'd0, NODE), exp_tail(32'hAAAA0001),
                exp_head(2'd2, NODE), exp_tail(32'hBBBB0002)};
      for (int i = 0; i < 4; i++)
         if (i < got.size()) check("ovf_flit", got[i], exp_q[i]);
      check("drain_full", tx_full, 1'b0);
      check("ovf_sticky", ovf_err, 1'b1);
      exp_tx_pkts += 2;

      // ---- receive with processor back-pressure
      send_flit(exp_head(NODE, 2'd2));
      send_flit(exp_tail(32'h12345678));
      for (int i = 0; i < 5; i++) begin
         check("hold_mips", mips_ni, 1'b1);
         check("hold_in_ready", flit_in_ready, 1'b0);
         check("hold_dv", data_valid, 1'b0);
         step();
      end
      proc_ready_in = 1'b1;
      #1;
      check("rx_dv", data_valid, 1'b1);
      check("rx_wd", wd_NI, 32'h12345678);
      step();
      proc_ready_in = 1'b0;
      check("rx_done_mips", mips_ni, 1'b0);
      check("rx_done_dv", data_valid, 1'b0);
      check("rx_done_ready", flit_in_ready, 1'b1);
      check("rx_wd_hold", wd_NI, 32'h12345678);
      check("rx_no_err", rx_err, 1'b0);

      // ---- protocol errors
      send_flit(exp_tail(32'h0000FFFF));
      check("err_tail_idle", rx_err, 1'b1);
      check("err_discard", mips_ni, 1'b0);
      proc_ready_in = 1'b1;
      send_flit(exp_head(NODE, 2'd0));
      send_flit(exp_head(NODE, 2'd3));
      send_flit(exp_tail(32'h000000A5));
      check("err_dv", data_valid, 1'b1);
      check("err_wd", wd_NI, 32'h000000A5);
      step();
      proc_ready_in = 1'b0;
      check("err_idle", mips_ni, 1'b0);

      // ---- reset in the middle of a TX tail stall and an RX hold
      flit_out_ready = 1'b0;
      proc_valid = 1'b1; proc_dest = 2'd2; proc_data = 32'h11110000;
      step();
      proc_data = 32'h22220000;
      step();
      proc_valid = 1'b0;
      flit_out_ready = 1'b1;
      flit_in = exp_head(NODE, 2'd3); flit_in_valid = 1'b1;
      step();
      flit_out_ready = 1'b0;
      flit_in = exp_tail(32'h00005555);
      step();
      flit_in_valid = 1'b0;
      check("pre_rst_valid", flit_out_valid, 1'b1);
      check("pre_rst_tail", flit_out, exp_tail(32'h11110000));
      check("pre_rst_mips", mips_ni, 1'b1);
      check("pre_rst_full", tx_full, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_valid", flit_out_valid, 1'b0);
      check("mid_rst_mips", mips_ni, 1'b0);
      check("mid_rst_full", tx_full, 1'b0);
      check("mid_rst_flit", flit_out, 34'h0);
      check("mid_rst_rx_err", rx_err, 1'b0);
      check("mid_rst_ovf", ovf_err, 1'b0);
      check("mid_rst_ready", flit_in_ready, 1'b1);
      exp_tx_pkts = 0;
      exp_rx_pkts = 0;
      step();
      rst = 1'b1;
      step();
      flit_out_ready = 1'b1;
      send_one(2'd1, 32'h0BADF00D);

      // ---- random TX traffic against a packet-queue model
      pend = 0; exp_ovf = 1'b0;
      exp_q.delete();
      for (int c = 0; c < 400; c++) begin
         if (c < 360) begin
            proc_valid     = 1'($urandom_range(0, 1));
            proc_dest      = 2'($urandom);
            proc_data      = $urandom;
            flit_out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            proc_valid     = 1'b0;
            flit_out_ready = 1'b1;
         end
         @(negedge clk);
         check("rnd_tx_full", tx_full, pend == DEPTH);
         check("rnd_ovf", ovf_err, exp_ovf);
         tail_done = 1'b0;
         if (flit_out_valid && flit_out_ready) begin
            check("rnd_hs_expected", flit_out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
               f = exp_q.pop_front();
               check("rnd_flit", flit_out, f);
               tail_done = (f[33:32] == 2'b01);
            end
         end
         if (proc_valid) begin
            if (pend < DEPTH) begin
               exp_q.push_back(exp_head(proc_dest, NODE));
               exp_q.push_back(exp_tail(proc_data));
               pend++;
            end else begin
               exp_ovf = 1'b1;
            end
         end
         if (tail_done) begin
            pend--;
            exp_tx_pkts++;
         end
         @(posedge clk);
         #1;
      end
      check("rnd_drain_left", 34'(exp_q.size()), 34'd0);
      check("rnd_drain_valid", flit_out_valid, 1'b0);

      // ---- random RX packets, some with protocol violations
      for (int p = 0; p < 24; p++) begin
         kind = $urandom_range(0, 4);
         d    = $urandom;
         if (kind == 1) begin
            send_flit(exp_tail($urandom));
            exp_rx_err = 1'b1;
         end
         if (kind == 2) begin
            send_flit({2'b11, 32'($urandom)});
            exp_rx_err = 1'b1;
         end
         if (kind == 4) begin
            send_flit(exp_head(NODE, 2'($urandom)));
            send_flit({2'b00, 32'($urandom)});
            exp_rx_err = 1'b1;
         end
         send_flit(exp_head(NODE, 2'($urandom)));
         if (kind == 3) begin
            send_flit(exp_head(NODE, 2'($urandom)));
            exp_rx_err = 1'b1;
         end
         send_flit(exp_tail(d));
         dly = $urandom_range(0, 3);
         for (int k = 0; k < dly; k++) begin
            check("rnd_rx_mips", mips_ni, 1'b1);
            check("rnd_rx_dv0", data_valid, 1'b0);
            check("rnd_rx_busy", flit_in_ready, 1'b0);
            step();
         end
         proc_ready_in = 1'b1;
         #1;
         check("rnd_rx_dv", data_valid, 1'b1);
         check("rnd_rx_wd", wd_NI, d);
         check("rnd_rx_err", rx_err, exp_rx_err);
         exp_rx_pkts++;
         step();
         proc_ready_in = 1'b0;
         check("rnd_rx_idle", mips_ni, 1'b0);
      end

`ifdef NI_STATS_EN
      check("stat_tx", tx_pkt_cnt, 16'(exp_tx_pkts));
      check("stat_rx", rx_pkt_cnt, 16'(exp_rx_pkts));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ni_proc_adapter.md
Name: ni_proc_adapter

Overview:
- Processor-side network interface: the other end of the core's NI port.
- TX path: takes processor send requests (proc_valid, proc_dest, proc_data), buffers them, and emits two-flit packets (head, tail) to the local router with valid/ready.
- RX path: reassembles incoming head+tail packets from the router and delivers the 32-bit payload to the core's register-file write port via mips_ni/data_valid/wd_NI.

Parameters:
- NODE_ID, 2'd0, this node's address; inserted as source field in head flits.
- TX_DEPTH, 2, TX request FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- proc_valid  in  1  processor send request, one cycle per message
- proc_dest  in  2  destination node of request
- proc_data  in  32  payload of request
- proc_ready_in  in  1  processor can accept received data this cycle
- tx_full  out  1  TX FIFO full; a request this cycle is dropped
- ovf_err  out  1  sticky: a request was dropped
- rx_err  out  1  sticky: RX protocol violation seen
- mips_ni  out  1  received message pending for processor
- data_valid  out  1  delivery strobe to processor
- wd_NI  out  32  received payload
- flit_out  out  34  flit to router
- flit_out_valid  out  1  flit_out valid
- flit_out_ready  in  1  router accepts flit_out
- flit_in  in  34  flit from router
- flit_in_valid  in  1  flit_in valid
- flit_in_ready  out  1  adapter accepts flit_in

Behaviour:
- Flit format:
  - [33:32] type: 2'b10 HEAD, 2'b01 TAIL, others illegal.
  - HEAD payload: [1:0] dest, [3:2] src, [31:4] zero.
  - TAIL payload: 32-bit data.
- Reset (rst low, async): all FSMs to IDLE, FIFO empty.
  - All outputs 0: tx_full, ovf_err, rx_err, mips_ni, data_valid, wd_NI, flit_out, flit_out_valid.
  - Exception: flit_in_ready=1.
  - In-flight packets are lost; flit_out_valid drops immediately.
- TX FIFO:
  - Push {dest,data} when proc_valid && !tx_full.
  - tx_full is the registered count==TX_DEPTH.
  - proc_valid while tx_full: request dropped, ovf_err set (sticky until reset), even if a pop happens the same cycle.
- TX FSM (TX_IDLE, TX_HEAD, TX_TAIL):
  - TX_IDLE: FIFO non-empty -> TX_HEAD.
  - TX_HEAD: flit_out_valid=1, flit_out = HEAD of FIFO front; on flit_out_ready -> TX_TAIL.
  - TX_TAIL: flit_out_valid=1, flit_out = TAIL with front data; on flit_out_ready pop FIFO, then -> TX_HEAD if entries remain, else TX_IDLE.
  - flit_out and flit_out_valid are registered and held stable until ready.
  - Latency: proc_valid sampled at edge N, head valid from cycle N+2.
  - Back-to-back packets have no idle cycle between tail and next head.
  - dest==NODE_ID is still sent to the router.
- RX FSM (RX_IDLE, RX_WAIT_TAIL, RX_HOLD):
  - flit_in_ready=1 in RX_IDLE and RX_WAIT_TAIL, 0 in RX_HOLD.
  - RX_IDLE:
    - HEAD accepted -> RX_WAIT_TAIL.
    - Any other type: consumed, discarded, rx_err set.
  - RX_WAIT_TAIL:
    - TAIL: wd_NI <= data -> RX_HOLD.
    - HEAD: rx_err set, restart waiting for tail.
    - Illegal type: rx_err set -> RX_IDLE.
  - RX_HOLD: mips_ni=1. data_valid = proc_ready_in (combinational, same cycle); when it is 1 -> RX_IDLE.
  - wd_NI holds its value until the next TAIL.
- TX and RX are fully independent; simultaneous activity is allowed.

Optional Feature:
- Macro: NI_STATS_EN.
- Defined: adds outputs tx_pkt_cnt[15:0] and rx_pkt_cnt[15:0].
  - tx_pkt_cnt increments on tail handshake; rx_pkt_cnt increments on data_valid.
  - Both wrap 16'hFFFF -> 0 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package noc_ni_pkg holds:
  - FLIT_W=34, DATA_W=32.
  - Flit type codes, HEAD field offsets.
  - TX and RX state enums.
- Sub-module ni_tx_fifo (parameter DEPTH):
  - Ports: push/pop/data_in/data_out/full/empty/count.
  - Async active-low reset.

Test Plan:
- Single send: proc_valid with dest=2'd3, data=32'hDEADBEEF, NODE_ID=1, router always ready -> HEAD payload 32'h7 at cycle N+2, then TAIL 32'hDEADBEEF at N+3; FIFO empty after.
- Back-pressure/overflow: flit_out_ready=0, three proc_valid pulses with TX_DEPTH=2 -> tx_full after second push, third dropped, ovf_err=1; releasing ready -> exactly 4 flits out; head/tail held stable while stalled.
- Receive: HEAD then TAIL 32'h12345678 with proc_ready_in=0 for 5 cycles -> mips_ni=1, flit_in_ready=0, data_valid=0; proc_ready_in=1 -> data_valid pulse one cycle, wd_NI=32'h12345678, then RX_IDLE.
- Protocol errors: TAIL in RX_IDLE -> rx_err=1, flit discarded; HEAD, HEAD, TAIL 32'hA5 -> wd_NI=32'hA5 delivered.
- Mid-operation reset: rst low during TX_TAIL stall and RX_HOLD -> flit_out_valid, mips_ni, tx_full low immediately; after release a new send completes normally.
- NI_STATS_EN: 3 sends and 2 receives -> tx_pkt_cnt=3, rx_pkt_cnt=2; preset near 16'hFFFF confirms wrap to 0.
